branch_resolve: RTL

//  Consumer end of the branch-predictor interface. Carries each branch's D-stage direction prediction
//  (pred_takeD), PC and target into E and compares it with the actual outcome. On a mismatch it raises a
//  one-shot mispredict with the redirect PC. It registers branchM/actual_takeM/pcM for the predictor's
//  M-stage BHT/PHT update, and keeps saturating branch and mispredict counters.

---
 rtl/branch_resolve.sv | 95 +++++++++
 1 files changed

// File: rtl/branch_resolve.sv
// Branch resolution in E: compares the carried D-stage prediction with the actual outcome,
// raises a one-shot redirect, and registers the M-stage predictor update plus stat counters.
module branch_resolve #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stallE,
    input  logic             flushE,
    input  logic             stallM,
    input  logic             flushM,
    input  logic             branchD,
    input  logic             pred_takeD,
    input  logic [31:0]      pcD,
    input  logic [31:0]      targetD,
    input  logic [31:0]      fallthruD,
    input  logic             actual_takeE,
    output logic             mispredE,
    output logic [31:0]      redirect_pcE,
    output logic             branchM,
    output logic             actual_takeM,
    output logic [31:0]      pcM,
    output logic [CNT_W-1:0] branch_cnt,
    output logic [CNT_W-1:0] mispred_cnt
);

    typedef struct packed {
        logic        branch;
        logic        predTake;
        logic [31:0] pc;
        logic [31:0] target;
        logic [31:0] fallthru;
    } eReg_t;

    eReg_t eQ;
    logic  resolvedE;
    logic  mLoad;

    assign mLoad = ~flushM & ~stallM & ~stallE;

    // resolvedE masks the compare once the redirect has gone out for a stalled branch
    assign mispredE = eQ.branch & (eQ.predTake ^ actual_takeE) & ~resolvedE;
    assign redirect_pcE = mispredE ? (actual_takeE ? eQ.target : eQ.fallthru) : 32'h0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            eQ        <= '0;
            resolvedE <= 1'b0;
        end else if (flushE) begin
            eQ        <= '0;
            resolvedE <= 1'b0;
        end else if (stallE) begin
            if (mispredE) resolvedE <= 1'b1;
        end else begin
            eQ        <= '{branchD, pred_takeD, pcD, targetD, fallthruD};
            resolvedE <= 1'b0;
        end
    end

    // A stalled E feeds bubbles so the predictor sees each branch once
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            branchM      <= 1'b0;
            actual_takeM <= 1'b0;
            pcM          <= 32'h0;
        end else if (flushM) begin
            branchM      <= 1'b0;
            actual_takeM <= 1'b0;
            pcM          <= 32'h0;
        end else if (stallM) begin
            branchM      <= branchM;
        end else if (stallE) begin
            branchM      <= 1'b0;
            actual_takeM <= 1'b0;
            pcM          <= 32'h0;
        end else begin
            branchM      <= eQ.branch;
            actual_takeM <= actual_takeE;
            pcM          <= eQ.pc;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            branch_cnt  <= '0;
            mispred_cnt <= '0;
        end else begin
            if (mLoad && eQ.branch && branch_cnt != '1)
                branch_cnt <= branch_cnt + CNT_W'(1);
            if (mispredE && mispred_cnt != '1)
                mispred_cnt <= mispred_cnt + CNT_W'(1);
        end
    end

endmodule
